// File: rtl/egress_pkt_arbiter_if.sv
// ----------------------------------------------------------------------------
// egress_pkt_arbiter_if
// Handshake bundle between the input-port FIFOs, one output mux and its
// packet arbiter.
//   req        per-input request for this output (held for the whole packet)
//   src_valid  per-input FIFO has a beat available
//   src_last   per-input current FIFO beat ends the packet
//   out_ready  downstream link accepts a beat this cycle
//   grant      registered one-hot grant (zero when idle)
//   mux_sel    registered index of the granted input
//   active     registered output-locked flag
//   out_valid  combinational: active & src_valid[mux_sel]
//   pop        combinational one-hot beat-accept strobe to the granted FIFO
//   rr_ptr     registered round-robin start pointer
//   beat_cnt   registered beats transferred in the current packet
//   abort      registered one-cycle pulse on abnormal packet termination
//   wdog_trip  registered one-cycle stall-watchdog pulse (ARB_WATCHDOG_EN only)
// Modports: master = arbiter side, slave = FIFO/link side.
// ----------------------------------------------------------------------------
interface egress_pkt_arbiter_if #(
  parameter int NUM_PORTS = 4,
  parameter int MAX_BEATS = 16
);
  localparam int SEL_W = $clog2(NUM_PORTS);
  localparam int CNT_W = $clog2(MAX_BEATS) + 1;

  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] src_valid;
  logic [NUM_PORTS-1:0] src_last;
  logic                 out_ready;
  logic [NUM_PORTS-1:0] grant;
  logic [SEL_W-1:0]     mux_sel;
  logic                 active;
  logic                 out_valid;
  logic [NUM_PORTS-1:0] pop;
  logic [SEL_W-1:0]     rr_ptr;
  logic [CNT_W-1:0]     beat_cnt;
  logic                 abort;
`ifdef ARB_WATCHDOG_EN
  logic                 wdog_trip;

  modport master (
    input  req, src_valid, src_last, out_ready,
    output grant, mux_sel, active, out_valid, pop, rr_ptr, beat_cnt, abort,
           wdog_trip
  );
  modport slave (
    output req, src_valid, src_last, out_ready,
    input  grant, mux_sel, active, out_valid, pop, rr_ptr, beat_cnt, abort,
           wdog_trip
  );
`else
  modport master (
    input  req, src_valid, src_last, out_ready,
    output grant, mux_sel, active, out_valid, pop, rr_ptr, beat_cnt, abort
  );
  modport slave (
    output req, src_valid, src_last, out_ready,
    input  grant, mux_sel, active, out_valid, pop, rr_ptr, beat_cnt, abort
  );
`endif
endinterface

// File: rtl/egress_pkt_arbiter.sv
// ----------------------------------------------------------------------------
// egress_pkt_arbiter
// Per-output-port packet scheduler. Round-robin picks one requesting input,
// locks the output to it for a whole packet, and strobes pop to the granted
// FIFO on each accepted beat. A packet ends on src_last, on reaching
// MAX_BEATS beats (abort), on the granted request dropping (abort) or, when
// ARB_WATCHDOG_EN is defined, after WDOG_CYCLES consecutive stalled cycles
// (abort + wdog_trip).
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   arb  egress_pkt_arbiter_if.master (req/src_valid/src_last/out_ready in;
//        grant/mux_sel/active/out_valid/pop/rr_ptr/beat_cnt/abort out,
//        plus wdog_trip with ARB_WATCHDOG_EN)
// Optional feature macro: ARB_WATCHDOG_EN
// ----------------------------------------------------------------------------
module egress_pkt_arbiter #(
  parameter int NUM_PORTS   = 4,
  parameter int MAX_BEATS   = 16,
  parameter int WDOG_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  egress_pkt_arbiter_if.master arb
);
  localparam int SEL_W = $clog2(NUM_PORTS);
  localparam int CNT_W = $clog2(MAX_BEATS) + 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]       state;
  logic [SEL_W-1:0] pick;
  logic [CNT_W-1:0] cnt_inc;
  logic             beat;
  logic             last_beat;
  logic             cap_hit;
  logic             req_drop;
  logic             wdog_hit;
  logic             rel_abort;
  logic             release_c;

  // First requesting port scanning start, start+1, ... (index wraps at SEL_W
  // bits since NUM_PORTS is a power of two). Scanning downwards lets the
  // nearest offset win.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_PORTS-1:0] r,
                                                input logic [SEL_W-1:0]     start);
    logic [SEL_W-1:0] idx;
    rr_pick = start;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      idx = start + SEL_W'(i);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  function automatic logic [NUM_PORTS-1:0] onehot(input logic [SEL_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  // ---- decode: beat acceptance and release conditions ----
  assign pick      = rr_pick(arb.req, arb.rr_ptr);
  assign cnt_inc   = arb.beat_cnt + CNT_W'(1);
  assign beat      = (state == BUSY) && arb.out_ready &&
                     arb.src_valid[arb.mux_sel] && arb.req[arb.mux_sel];
  assign last_beat = beat && arb.src_last[arb.mux_sel];
  assign cap_hit   = beat && !arb.src_last[arb.mux_sel] &&
                     (cnt_inc == CNT_W'(MAX_BEATS));
  assign req_drop  = (state == BUSY) && !arb.req[arb.mux_sel];
  assign rel_abort = cap_hit || req_drop || wdog_hit;
  assign release_c = last_beat || rel_abort;

  // Reset cycle must never pop, even if a beat would otherwise qualify.
  assign arb.pop       = (beat && !rst) ? onehot(arb.mux_sel) : '0;
  assign arb.out_valid = arb.active && arb.src_valid[arb.mux_sel];

  // ---- register: grant lock, pointer, beat count ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      arb.grant    <= '0;
      arb.mux_sel  <= '0;
      arb.active   <= 1'b0;
      arb.rr_ptr   <= '0;
      arb.beat_cnt <= '0;
      arb.abort    <= 1'b0;
    end else begin
      arb.abort <= 1'b0;
      case (state)
        IDLE: begin
          if (|arb.req) begin
            state        <= BUSY;
            arb.grant    <= onehot(pick);
            arb.mux_sel  <= pick;
            arb.active   <= 1'b1;
            arb.beat_cnt <= '0;
          end
        end
        BUSY: begin
          if (release_c) begin
            state        <= IDLE;
            arb.grant    <= '0;
            arb.active   <= 1'b0;
            arb.rr_ptr   <= arb.mux_sel + SEL_W'(1);
            arb.beat_cnt <= '0;
            arb.abort    <= rel_abort;
          end else if (beat) begin
            arb.beat_cnt <= cnt_inc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ARB_WATCHDOG_EN
  // ---- stall watchdog: consecutive BUSY cycles without a beat ----
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

  logic [WDOG_W-1:0] stall_cnt;

  // Fires on the WDOG_CYCLES-th stalled cycle so the release lands after
  // exactly that many stalls.
  assign wdog_hit = (state == BUSY) && !beat &&
                    (stall_cnt == WDOG_W'(WDOG_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt     <= '0;
      arb.wdog_trip <= 1'b0;
    end else begin
      arb.wdog_trip <= wdog_hit;
      if ((state != BUSY) || beat || release_c) stall_cnt <= '0;
      else                                      stall_cnt <= stall_cnt + WDOG_W'(1);
    end
  end
`else
  assign wdog_hit = 1'b0;
`endif

endmodule

// File: tb/tb_egress_pkt_arbiter.sv
module tb_egress_pkt_arbiter;
  localparam int NP = 4;
  localparam int MB = 16;
  localparam int WD = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  egress_pkt_arbiter_if #(.NUM_PORTS(NP), .MAX_BEATS(MB)) bus ();

  egress_pkt_arbiter #(.NUM_PORTS(NP), .MAX_BEATS(MB), .WDOG_CYCLES(WD)) dut (
    .clk (clk),
    .rst (rst),
    .arb (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [NP-1:0] pop_q[$];    // expected pop vectors, one per driven beat cycle
  int            grant_q[$];  // expected grant order

  task automatic drive(input logic [NP-1:0] r, input logic [NP-1:0] v,
                       input logic [NP-1:0] l, input logic rdy);
    bus.req       = r;
    bus.src_valid = v;
    bus.src_last  = l;
    bus.out_ready = rdy;
  endtask

  task automatic apply_reset;
    rst = 1'b1;
    drive('0, '0, '0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    apply_reset();
    n_checks++; if ({bus.grant, bus.mux_sel, bus.active, bus.rr_ptr, bus.beat_cnt, bus.abort} !== 15'd0) begin
      n_fail++; $display("FAIL reset_state got %b want 0", {bus.grant, bus.mux_sel, bus.active, bus.rr_ptr, bus.beat_cnt, bus.abort});
    end
    #1;
    n_checks++; if (bus.pop !== 4'b0000) begin n_fail++; $display("FAIL reset_pop got %b want 0000", bus.pop); end
  endtask

  task automatic test_basic;
    logic [NP-1:0] exp;
    apply_reset();
    drive(4'b0101, 4'b0101, 4'b0000, 1'b1);
    #1;
    n_checks++; if (bus.pop !== 4'b0000) begin n_fail++; $display("FAIL basic_idle_pop got %b want 0000", bus.pop); end
    @(negedge clk);
    n_checks++; if (bus.grant !== 4'b0001) begin n_fail++; $display("FAIL basic_grant got %b want 0001", bus.grant); end
    n_checks++; if (bus.active !== 1'b1 || bus.mux_sel !== 2'd0 || bus.beat_cnt !== 5'd0) begin
      n_fail++; $display("FAIL basic_lock got act=%b sel=%0d cnt=%0d want 1/0/0", bus.active, bus.mux_sel, bus.beat_cnt);
    end
    for (int b = 0; b < 3; b++) begin
      drive(4'b0101, 4'b0101, (b == 2) ? 4'b0001 : 4'b0000, 1'b1);
      pop_q.push_back(4'b0001);
      #1;
      exp = pop_q.pop_front();
      n_checks++; if (bus.pop !== exp) begin n_fail++; $display("FAIL basic_pop%0d got %b want %b", b, bus.pop, exp); end
      @(negedge clk);
      if (b < 2) begin
        n_checks++; if (bus.beat_cnt !== 5'(b + 1)) begin n_fail++; $display("FAIL basic_cnt%0d got %0d want %0d", b, bus.beat_cnt, b + 1); end
      end
    end
    n_checks++; if (bus.active !== 1'b0 || bus.grant !== 4'b0000 || bus.abort !== 1'b0) begin
      n_fail++; $display("FAIL basic_release got act=%b gnt=%b abort=%b want 0/0000/0", bus.active, bus.grant, bus.abort);
    end
    n_checks++; if (bus.rr_ptr !== 2'd1) begin n_fail++; $display("FAIL basic_rr got %0d want 1", bus.rr_ptr); end
    drive(4'b0100, 4'b0100, 4'b0100, 1'b1);
    #1;
    n_checks++; if (bus.pop !== 4'b0000) begin n_fail++; $display("FAIL basic_gap_pop got %b want 0000", bus.pop); end
    @(negedge clk);
    n_checks++; if (bus.grant !== 4'b0100 || bus.mux_sel !== 2'd2) begin
      n_fail++; $display("FAIL basic_next_grant got gnt=%b sel=%0d want 0100/2", bus.grant, bus.mux_sel);
    end
    pop_q.push_back(4'b0100);
    #1;
    exp = pop_q.pop_front();
    n_checks++; if (bus.pop !== exp) begin n_fail++; $display("FAIL basic_p2_pop got %b want %b", bus.pop, exp); end
    @(negedge clk);
    n_checks++; if (bus.rr_ptr !== 2'd3 || bus.active !== 1'b0) begin
      n_fail++; $display("FAIL basic_p2_release got rr=%0d act=%b want 3/0", bus.rr_ptr, bus.active);
    end
    drive('0, '0, '0, 1'b1);
  endtask

  task automatic test_round_robin;
    int exp;
    apply_reset();
    for (int k = 0; k < 5; k++) grant_q.push_back(k % NP);
    drive(4'b1111, 4'b1111, 4'b1111, 1'b1);
    for (int k = 0; k < 5; k++) begin
      #1;
      n_checks++; if (bus.pop !== 4'b0000 || bus.active !== 1'b0) begin
        n_fail++; $display("FAIL rr_gap%0d got pop=%b act=%b want 0000/0", k, bus.pop, bus.active);
      end
      @(negedge clk);
      exp = grant_q.pop_front();
      n_checks++; if (bus.grant !== 4'(1 << exp) || bus.mux_sel !== 2'(exp)) begin
        n_fail++; $display("FAIL rr_grant%0d got gnt=%b sel=%0d want port %0d", k, bus.grant, bus.mux_sel, exp);
      end
      #1;
      n_checks++; if (bus.pop !== 4'(1 << exp)) begin n_fail++; $display("FAIL rr_pop%0d got %b want port %0d", k, bus.pop, exp); end
      @(negedge clk);
      n_checks++; if (bus.active !== 1'b0 || bus.rr_ptr !== 2'((exp + 1) % NP)) begin
        n_fail++; $display("FAIL rr_ptr%0d got rr=%0d act=%b want %0d/0", k, bus.rr_ptr, bus.active, (exp + 1) % NP);
      end
    end
    drive('0, '0, '0, 1'b1);
  endtask

  task automatic test_stall;
    logic       rdy_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [4:0] cnt_pat [4] = '{5'd1, 5'd1, 5'd1, 5'd0};
    logic [NP-1:0] exp;
    drive(4'b1000, 4'b1000, 4'b0000, 1'b1);
    @(negedge clk);
    n_checks++; if (bus.grant !== 4'b1000 || bus.beat_cnt !== 5'd0) begin
      n_fail++; $display("FAIL stall_grant got gnt=%b cnt=%0d want 1000/0", bus.grant, bus.beat_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      drive(4'b1000, 4'b1000, (i == 3) ? 4'b1000 : 4'b0000, rdy_pat[i]);
      pop_q.push_back(rdy_pat[i] ? 4'b1000 : 4'b0000);
      #1;
      exp = pop_q.pop_front();
      n_checks++; if (bus.pop !== exp || bus.out_valid !== 1'b1) begin
        n_fail++; $display("FAIL stall_pop%0d got pop=%b ov=%b want %b/1", i, bus.pop, bus.out_valid, exp);
      end
      @(negedge clk);
      n_checks++; if (bus.beat_cnt !== cnt_pat[i] || bus.active !== (i < 3)) begin
        n_fail++; $display("FAIL stall_cnt%0d got cnt=%0d act=%b want %0d/%0d", i, bus.beat_cnt, bus.active, cnt_pat[i], i < 3);
      end
    end
    n_checks++; if (bus.abort !== 1'b0 || bus.rr_ptr !== 2'd0) begin
      n_fail++; $display("FAIL stall_release got abort=%b rr=%0d want 0/0", bus.abort, bus.rr_ptr);
    end
    drive('0, '0, '0, 1'b1);
  endtask

  task automatic test_forced_release;
    logic [NP-1:0] exp;
    drive(4'b0010, 4'b0010, 4'b0000, 1'b1);
    @(negedge clk);
    n_checks++; if (bus.grant !== 4'b0010) begin n_fail++; $display("FAIL force_grant got %b want 0010", bus.grant); end
    for (int k = 1; k <= MB; k++) begin
      pop_q.push_back(4'b0010);
      #1;
      exp = pop_q.pop_front();
      n_checks++; if (bus.pop !== exp) begin n_fail++; $display("FAIL force_pop%0d got %b want %b", k, bus.pop, exp); end
      @(negedge clk);
      if (k < MB) begin
        n_checks++; if (bus.beat_cnt !== 5'(k) || bus.abort !== 1'b0) begin
          n_fail++; $display("FAIL force_cnt%0d got cnt=%0d abort=%b want %0d/0", k, bus.beat_cnt, bus.abort, k);
        end
      end
    end
    n_checks++; if (bus.active !== 1'b0 || bus.abort !== 1'b1 || bus.beat_cnt !== 5'd0 || bus.rr_ptr !== 2'd2) begin
      n_fail++; $display("FAIL force_release got act=%b abort=%b cnt=%0d rr=%0d want 0/1/0/2", bus.active, bus.abort, bus.beat_cnt, bus.rr_ptr);
    end
    drive('0, '0, '0, 1'b1);
    @(negedge clk);
    n_checks++; if (bus.abort !== 1'b0 || bus.active !== 1'b0) begin
      n_fail++; $display("FAIL force_abort_pulse got abort=%b act=%b want 0/0", bus.abort, bus.active);
    end
  endtask

  task automatic test_req_drop_and_reset;
    logic [NP-1:0] exp;
    drive(4'b0100, 4'b0100, 4'b0000, 1'b1);
    @(negedge clk);
    n_checks++; if (bus.grant !== 4'b0100) begin n_fail++; $display("FAIL drop_grant got %b want 0100", bus.grant); end
    for (int b = 0; b < 2; b++) begin
      pop_q.push_back(4'b0100);
      #1;
      exp = pop_q.pop_front();
      n_checks++; if (bus.pop !== exp) begin n_fail++; $display("FAIL drop_pop%0d got %b want %b", b, bus.pop, exp); end
      @(negedge clk);
    end
    drive(4'b0000, 4'b0100, 4'b0000, 1'b1);
    #1;
    n_checks++; if (bus.pop !== 4'b0000) begin n_fail++; $display("FAIL drop_cycle_pop got %b want 0000", bus.pop); end
    @(negedge clk);
    n_checks++; if (bus.active !== 1'b0 || bus.abort !== 1'b1 || bus.rr_ptr !== 2'd3) begin
      n_fail++; $display("FAIL drop_release got act=%b abort=%b rr=%0d want 0/1/3", bus.active, bus.abort, bus.rr_ptr);
    end
    drive(4'b0001, 4'b0001, 4'b0000, 1'b1);
    @(negedge clk);
    n_checks++; if (bus.abort !== 1'b0 || bus.grant !== 4'b0001) begin
      n_fail++; $display("FAIL drop_regrant got abort=%b gnt=%b want 0/0001", bus.abort, bus.grant);
    end
    #1;
    @(negedge clk);
    n_checks++; if (bus.beat_cnt !== 5'd1) begin n_fail++; $display("FAIL rstmid_cnt got %0d want 1", bus.beat_cnt); end
    rst = 1'b1;
    #1;
    n_checks++; if (bus.pop !== 4'b0000) begin n_fail++; $display("FAIL rstmid_pop got %b want 0000", bus.pop); end
    @(negedge clk);
    n_checks++; if ({bus.grant, bus.mux_sel, bus.active, bus.rr_ptr, bus.beat_cnt, bus.abort} !== 15'd0) begin
      n_fail++; $display("FAIL rstmid_state got %b want 0", {bus.grant, bus.mux_sel, bus.active, bus.rr_ptr, bus.beat_cnt, bus.abort});
    end
    rst = 1'b0;
    drive('0, '0, '0, 1'b0);
  endtask

`ifdef ARB_WATCHDOG_EN
  task automatic test_watchdog;
    apply_reset();
    drive(4'b0001, 4'b0000, 4'b0000, 1'b1);
    @(negedge clk);
    n_checks++; if (bus.grant !== 4'b0001) begin n_fail++; $display("FAIL wdog_grant got %b want 0001", bus.grant); end
    for (int s = 1; s <= WD; s++) begin
      #1;
      n_checks++; if (bus.pop !== 4'b0000) begin n_fail++; $display("FAIL wdog_pop%0d got %b want 0000", s, bus.pop); end
      @(negedge clk);
      if (s < WD) begin
        n_checks++; if (bus.active !== 1'b1 || bus.wdog_trip !== 1'b0 || bus.abort !== 1'b0) begin
          n_fail++; $display("FAIL wdog_hold%0d got act=%b trip=%b abort=%b want 1/0/0", s, bus.active, bus.wdog_trip, bus.abort);
        end
      end
    end
    n_checks++; if (bus.wdog_trip !== 1'b1 || bus.abort !== 1'b1 || bus.active !== 1'b0 || bus.rr_ptr !== 2'd1) begin
      n_fail++; $display("FAIL wdog_trip got trip=%b abort=%b act=%b rr=%0d want 1/1/0/1", bus.wdog_trip, bus.abort, bus.active, bus.rr_ptr);
    end
    drive('0, '0, '0, 1'b1);
    @(negedge clk);
    n_checks++; if (bus.wdog_trip !== 1'b0 || bus.abort !== 1'b0) begin
      n_fail++; $display("FAIL wdog_pulse got trip=%b abort=%b want 0/0", bus.wdog_trip, bus.abort);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    drive('0, '0, '0, 1'b0);
    test_reset();
    test_basic();
    test_round_robin();
    test_stall();
    test_forced_release();
    test_req_drop_and_reset();
`ifdef ARB_WATCHDOG_EN
    test_watchdog();
`endif
    n_checks++; if (pop_q.size() != 0 || grant_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain got %0d/%0d entries want 0/0", pop_q.size(), grant_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no finish want finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
